// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding, default sizes and onehot/index helpers
// for the FIFO write-port arbiter.
package fifo_arb_pkg;

    localparam int N_DEF = 4;
    localparam int DW_DEF = 8;
    localparam int MAX_N = 32;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    function automatic logic [MAX_N-1:0] idx_to_onehot(input logic [31:0] idx);
        return MAX_N'(1) << idx;
    endfunction

    function automatic logic [31:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++)
            r = oh[i] ? 32'(i) : r;
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: combinational rotating priority encoder; picks the first
// set request starting at rr_ptr and wrapping modulo N.
module rr_priority_select #(
    parameter int N = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0] rot;

    // Rotating the doubled vector puts req[rr_ptr] at bit 0, so the lowest set
    // bit of rot is the winner; scanning downwards leaves the lowest one last.
    always_comb begin
        rot = N'({req, req} >> rr_ptr);
        any = |req;
        idx = '0;
        for (int k = N - 1; k >= 0; k--)
            idx = rot[k] ? IDX_W'((int'(rr_ptr) + k) % N) : idx;
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: packet-locked round-robin sharing of one FIFO write port.
// Define PKT_TIMEOUT_EN to build the idle-owner timeout that forcibly drops the lock.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int DW = DW_DEF,
    parameter int IDX_W = $clog2(N),
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [N-1:0]      valid,
    input  logic [N-1:0]      eop,
    input  logic [N*DW-1:0]   data,
    output logic [N-1:0]      ready,
    output logic [N-1:0]      grant,
    output logic [IDX_W-1:0]  owner_idx,
    input  logic              wfull,
    output logic              winc,
    output logic [DW-1:0]     wdata,
    output logic              timeout
);

    arb_state_t       state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d, rr_q, rr_d;
    logic [IDX_W-1:0] sel_idx, next_ptr;
    logic             sel_any, owner_valid, owner_eop, done, tmo;

    rr_priority_select #(.N(N), .IDX_W(IDX_W)) u_sel (
        .req    (req),
        .rr_ptr (rr_q),
        .any    (sel_any),
        .idx    (sel_idx)
    );

    // grant_q is all-zero in IDLE, so the mux below yields zeros there for free.
    always_comb begin
        owner_valid = |(valid & grant_q);
        owner_eop = |(eop & grant_q);
        wdata = '0;
        for (int i = 0; i < N; i++)
            wdata = wdata | (data[i*DW +: DW] & {DW{grant_q[i]}});
    end

    assign winc = owner_valid & ~wfull;
    assign ready = wfull ? '0 : grant_q;
    assign done = winc & owner_eop;
    assign next_ptr = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);
    assign grant = grant_q;
    assign owner_idx = idx_q;
    assign timeout = tmo;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d = idx_q;
        rr_d = rr_q;
        if (state_q == IDLE) begin
            if (sel_any) begin
                state_d = LOCK;
                grant_d = N'(idx_to_onehot(32'(sel_idx)));
                idx_d = sel_idx;
            end
        end else if (done || tmo) begin
            state_d = IDLE;
            grant_d = '0;
            rr_d = next_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q <= '0;
            rr_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q <= idx_d;
            rr_q <= rr_d;
        end
    end

`ifdef PKT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer_q, timer_d;

    // Only cycles where the owner presents nothing count; wfull stalls keep valid high.
    always_comb begin
        tmo = (state_q == LOCK) && !owner_valid && (timer_q == TW'(TIMEOUT - 1));
        timer_d = (state_q == LOCK && !owner_valid && !tmo) ? timer_q + TW'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            timer_q <= '0;
        else
            timer_q <= timer_d;
    end
`else
    assign tmo = 1'b0;
`endif

endmodule
